// File: rtl/cp0_epc_writer_if.sv
// Bus between the M stage of the pipeline and the CP0 register block.
// Timing contract: there is no valid/ready handshake on this bus. Every input is
// sampled at each rising clock edge, We and eret act as single-cycle strobes, and
// IntReq and DOut respond combinationally in the same cycle as the inputs.
interface cp0_epc_writer_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        bd;
    logic [4:0]  ExcCode_in;
    logic [5:0]  HWInt;
    logic        eret;
    logic        IntReq;
    logic [31:0] EPC_out;
    logic [31:0] DOut;

    // Pipeline side: drives the M-stage request, observes IntReq and the read data
    modport master (
        output A1, A2, DIn, We, PC, bd, ExcCode_in, HWInt, eret,
        input  IntReq, EPC_out, DOut
    );

    // CP0 side
    modport slave (
        input  A1, A2, DIn, We, PC, bd, ExcCode_in, HWInt, eret,
        output IntReq, EPC_out, DOut
    );
endinterface

// File: rtl/cp0_epc_writer.sv
// CP0 register block at the M stage: SR(12), Cause(13), EPC(14), PRId(15).
// Decides exception/interrupt entry (IntReq), records EPC/Cause/EXL on entry,
// serves mfc0 reads and mtc0 writes, and clears EXL on eret.
module cp0_epc_writer #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2019
) (
    input  logic           clk,
    input  logic           reset,
    cp0_epc_writer_if.slave bus
);
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Only the architecturally meaningful fields are stored; all other bits read 0.
    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic        int_req;
    logic [31:0] pc_word;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Pending-request decode; EXL masks everything, and reset forces IntReq low
    // even if ExcCode_in is already non-zero.
    always_comb begin
        int_pend = (|(bus.HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        exc_pend = (bus.ExcCode_in != 5'd0) & ~sr_exl_q;
        int_req  = ~reset & (int_pend | exc_pend);
        pc_word  = bus.PC & 32'hFFFF_FFFC;
    end

    // Next-state: exception entry overrides mtc0 and eret (the instruction is flushed)
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        cause_ip_d  = bus.HWInt;
        if (int_req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = bus.bd;
            cause_exc_d = int_pend ? 5'd0 : bus.ExcCode_in;
            // A delay-slot victim restarts at its branch; wraps mod 2^32.
            epc_d       = bus.bd ? (pc_word - 32'd4) : pc_word;
        end else begin
            if (bus.We && (bus.A2 == REG_SR)) begin
                sr_im_d  = bus.DIn[15:10];
                sr_exl_d = bus.DIn[1];
                sr_ie_d  = bus.DIn[0];
            end
            if (bus.We && (bus.A2 == REG_EPC)) begin
                epc_d = bus.DIn & 32'hFFFF_FFFC;
            end
            if (bus.eret) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // Register state with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // Read mux from registered values only: a same-cycle write is not bypassed
    always_comb begin
        sr_word    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
        cause_word = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
        case (bus.A1)
            REG_SR:    bus.DOut = sr_word;
            REG_CAUSE: bus.DOut = cause_word;
            REG_EPC:   bus.DOut = epc_q;
            REG_PRID:  bus.DOut = PRID_VALUE;
            default:   bus.DOut = 32'd0;
        endcase
    end

    assign bus.IntReq  = int_req;
    assign bus.EPC_out = epc_q;
endmodule

// File: tb/tb_cp0_epc_writer.sv
// Bench for cp0_epc_writer: directed scenarios plus randomized traffic, checked
// against a word-level model of SR/Cause/EPC kept in this file.
module tb_cp0_epc_writer;
    localparam logic [31:0] PRID = 32'h0000_2019;

    logic clk;
    logic reset;
    cp0_epc_writer_if bus();

    cp0_epc_writer #(.PRID_VALUE(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    // Reference state held as whole register words
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_sr    = 32'd0;
        m_cause = 32'd0;
        m_epc   = 32'd0;
    endtask

    task automatic drive_idle();
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.We = 1'b0;
        bus.PC = 32'd0; bus.bd = 1'b0; bus.ExcCode_in = 5'd0;
        bus.HWInt = 6'd0; bus.eret = 1'b0;
    endtask

    // One M-stage cycle: called at posedge+1, drives inputs, checks the
    // combinational outputs, then advances the model across the edge.
    task automatic cycle(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                         input logic we, input logic [31:0] pc, input logic bd_i,
                         input logic [4:0] exc, input logic [5:0] hw, input logic er);
        logic int_pend;
        logic take;
        logic [31:0] got_dout;
        bus.A1 = a1; bus.A2 = a2; bus.DIn = din; bus.We = we; bus.PC = pc;
        bus.bd = bd_i; bus.ExcCode_in = exc; bus.HWInt = hw; bus.eret = er;
        #1;
        int_pend = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        take     = int_pend || ((exc != 5'd0) && !m_sr[1]);
        exp_q.push_back(model_read(a1));
        got_dout = bus.DOut;
        check_val("intreq", {31'd0, bus.IntReq}, {31'd0, take});
        check_val("dout", got_dout, exp_q.pop_front());
        check_val("epc_out", bus.EPC_out, m_epc);
        @(posedge clk);
        #1;
        m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
        if (take) begin
            m_sr    = m_sr | 32'h2;
            m_cause = (m_cause & 32'h0000_FC00) | ({31'd0, bd_i} << 31)
                    | ({27'd0, (int_pend ? 5'd0 : exc)} << 2);
            m_epc   = (pc & ~32'd3) - (bd_i ? 32'd4 : 32'd0);
        end else begin
            if (we && a2 == 5'd12) m_sr = din & 32'h0000_FC03;
            if (we && a2 == 5'd14) m_epc = din & ~32'd3;
            if (er) m_sr = m_sr & ~32'h2;
        end
    endtask

    // Between-edge read of a register against an explicitly stated value
    task automatic peek(input string tag, input logic [4:0] a1, input logic [31:0] exp);
        bus.A1 = a1;
        #1;
        check_val(tag, bus.DOut, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        peek("rst_sr", 5'd12, 32'd0);
        peek("rst_epc", 5'd14, 32'd0);

        // Interrupt entry
        cycle(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        peek("sr_after_mtc0", 5'd12, 32'h0000_0401);
        cycle(5'd14, 5'd0, 32'd0, 1'b0, 32'h3010, 1'b0, 5'd0, 6'b000001, 1'b0);
        peek("irq_epc", 5'd14, 32'h3010);
        peek("irq_cause", 5'd13, 32'h0000_0400);
        peek("irq_sr", 5'd12, 32'h0000_0403);
        check_val("irq_masked", {31'd0, bus.IntReq}, 32'd0);

        // eret and masking: interrupt stays pending while EXL is set
        cycle(5'd13, 5'd0, 32'd0, 1'b0, 32'h3014, 1'b0, 5'd0, 6'b000001, 1'b0);
        cycle(5'd12, 5'd0, 32'd0, 1'b0, 32'h3018, 1'b0, 5'd0, 6'b000001, 1'b1);
        check_val("eret_intreq", {31'd0, bus.IntReq}, 32'd1);
        check_val("eret_epc_out", bus.EPC_out, 32'h3010);
        peek("eret_sr", 5'd12, 32'h0000_0401);

        // Exception in delay slot
        cycle(5'd13, 5'd0, 32'd0, 1'b0, 32'h3020, 1'b1, 5'd10, 6'd0, 1'b0);
        peek("ds_epc", 5'd14, 32'h301C);
        peek("ds_cause", 5'd13, 32'h8000_0028);
        peek("ds_sr", 5'd12, 32'h0000_0403);
        cycle(5'd12, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);

        // Simultaneous interrupt, exception and mtc0 to EPC
        cycle(5'd14, 5'd14, 32'hDEAD_BEEF, 1'b1, 32'h3040, 1'b0, 5'd4, 6'b000001, 1'b0);
        peek("sim_epc", 5'd14, 32'h3040);
        peek("sim_cause", 5'd13, 32'h0000_0400);
        cycle(5'd12, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);

        // mfc0 reads, including a read of EPC while it is being written
        cycle(5'd15, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle(5'd13, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle(5'd3, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        peek("prid", 5'd15, PRID);
        peek("rd_other", 5'd3, 32'd0);
        cycle(5'd14, 5'd14, 32'h4001, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        peek("epc_wr", 5'd14, 32'h4000);

        // Wrap: delay-slot victim at PC 0 (clear IE first so only the exception fires)
        cycle(5'd12, 5'd12, 32'd0, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle(5'd14, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd8, 6'd0, 1'b0);
        peek("wrap_epc", 5'd14, 32'hFFFF_FFFC);

        // Reset mid-operation: EXL=1, EPC=0x3004, then reset between edges
        cycle(5'd12, 5'd12, 32'h0000_0002, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle(5'd14, 5'd14, 32'h3004, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        peek("pre_rst_epc", 5'd14, 32'h3004);
        bus.ExcCode_in = 5'd5;
        bus.HWInt = 6'h3F;
        #1;
        reset = 1'b1;
        #1;
        check_val("rst_intreq", {31'd0, bus.IntReq}, 32'd0);
        check_val("rst_epc_out", bus.EPC_out, 32'd0);
        peek("rst_mid_sr", 5'd12, 32'd0);
        peek("rst_mid_cause", 5'd13, 32'd0);
        peek("rst_mid_epc", 5'd14, 32'd0);
        drive_idle();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] a1, a2, exc;
            logic [5:0] hw;
            a1  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'(12 + $urandom_range(0, 3));
            a2  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'(12 + $urandom_range(0, 3));
            exc = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw  = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'd0;
            cycle(a1, a2, $urandom, ($urandom_range(0, 2) == 0), $urandom,
                  1'($urandom), exc, hw, ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cp0_epc_writer.md
Name: cp0_epc_writer

Overview:
- Coprocessor-0 register block of the pipelined MIPS core, located at the M stage.
- On exception entry it is the writer of EPC, Cause and SR.EXL; the eret / next-PC path only reads EPC_out.
- Holds SR(12), Cause(13), EPC(14) and PRId(15).
- Serves mfc0 reads and mtc0 writes, and raises IntReq to flush the pipeline and redirect to the handler.

Parameters:
- PRID_VALUE, 32'h0000_2019, constant returned when reading PRId (reg 15).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- A1  input  5  mfc0 read address (rd field).
- A2  input  5  mtc0 write address (rd field).
- DIn  input  32  mtc0 write data.
- We  input  1  mtc0 write enable (M-stage mtc0).
- PC  input  32  PC of the M-stage instruction (victim).
- bd  input  1  victim instruction is in a branch delay slot.
- ExcCode_in  input  5  internal exception code from the pipeline; 0 = none.
- HWInt  input  6  external hardware interrupt lines, level-sensitive.
- eret  input  1  M-stage eret.
- IntReq  output  1  take exception/interrupt this cycle.
- EPC_out  output  32  current EPC value.
- DOut  output  32  mfc0 read data.

Behaviour:
- Register fields:
  - SR: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC: 32 bits, bits[1:0] always 0.
- Reset (async, immediate): SR=0, Cause=0, EPC=0. IntReq=0 while reset is high. EPC_out=0.
- Combinational terms:
  - int_pend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL
  - exc_pend = (ExcCode_in != 0) & ~SR.EXL
  - IntReq = int_pend | exc_pend, with zero latency (same cycle as inputs).
- Cause.IP <= HWInt every cycle, unconditionally, including the cycle IntReq is taken.
- On the clock edge with IntReq=1:
  - SR.EXL <= 1.
  - Cause.BD <= bd.
  - Cause.ExcCode <= 0 if int_pend, else ExcCode_in. An interrupt has priority over a simultaneous internal exception.
  - EPC <= bd ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
- mtc0 (We=1 and IntReq=0):
  - A2=12 writes SR.IM, SR.EXL and SR.IE from DIn; other bits are ignored.
  - A2=14 writes EPC <= {DIn[31:2],2'b00}.
  - A2=13, A2=15 and other addresses: no effect.
- Simultaneous IntReq and We: IntReq wins; the mtc0 is discarded (the instruction is being flushed).
- eret (IntReq=0): SR.EXL <= 0 at the edge. EPC is unchanged.
- Simultaneous eret and IntReq: IntReq wins; EXL ends at 1. This is only possible when EXL=0 already.
- While EXL=1, further interrupts and exceptions are masked. Cause.IP still tracks HWInt.
- Read path, combinational: DOut = selected register for A1 in {12,13,14,15}; 0 for any other A1.
  - Read of PRId returns PRID_VALUE.
  - Read of a register being written in the same cycle returns the old value (no internal bypass).
- EPC_out = EPC register (registered value, zero-latency read).
- PC arithmetic wraps mod 2^32: bd with PC=0 gives EPC=32'hFFFF_FFFC.

Test Plan:
- Reset mid-operation:
  - Stimulus: EXL=1, EPC=32'h3004, then assert reset between edges.
  - Required: SR, Cause, EPC and EPC_out = 0 immediately; IntReq=0 while reset is high.
- Interrupt entry:
  - Stimulus: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1); then HWInt=6'b000001, PC=32'h3010, bd=0.
  - Required: IntReq=1 same cycle; next cycle EPC=32'h3010, Cause.ExcCode=0, IP=6'b000001, SR.EXL=1, IntReq=0.
- Exception in delay slot:
  - Stimulus: ExcCode_in=5'd10, bd=1, PC=32'h3020.
  - Required: EPC=32'h301C, Cause=32'h8000_0028, EXL=1.
- Simultaneous interrupt, exception and mtc0:
  - Stimulus: HWInt enabled, ExcCode_in=5'd4, We=1, A2=14, DIn=32'hDEAD_BEEF.
  - Required: ExcCode=0, EPC=PC (not DEADBEEC).
- eret and masking:
  - Stimulus: EXL=1, assert HWInt (IntReq must stay 0), then eret=1.
  - Required: next cycle EXL=0, IntReq=1 (interrupt still pending), EPC_out unchanged.
- mfc0 reads:
  - Stimulus: A1=15, A1=13, A1=3, and A1=14 in the same cycle as a mtc0 write to 14 with DIn=32'h4001.
  - Required: DOut = PRID_VALUE; current Cause; 0; old EPC in that cycle, then 32'h4000 on the next cycle.
